// File: rtl/red_pitaya_hk_gpio_if.sv
// Housekeeping system-bus bundle for the expansion GPIO block.
// The master drives address, data and strobes; the slave returns read data and the acknowledge.
interface red_pitaya_hk_gpio_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_hk_gpio.sv
// Expansion-connector GPIO: NB banks of DW bits with synchronised and debounced inputs,
// per-bit rise/fall capture into sticky status bits and a globally gated level interrupt.
module red_pitaya_hk_gpio #(
    parameter int DW  = 8,
    parameter int NB  = 2,
    parameter int DBW = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [NB*DW-1:0]     gpio_dat_i,
    output logic [NB*DW-1:0]     gpio_dat_o,
    output logic [NB*DW-1:0]     gpio_dir_o,
    output logic                 irq_o,
    red_pitaya_hk_gpio_if.slave  sys
);

    localparam int W = NB * DW;

    logic [W-1:0]   sync1_reg, sync2_reg;
    logic [W-1:0]   smp_reg, deb_reg, deb_q_reg;
    logic [W-1:0]   rise, fall;
    logic [W-1:0]   ists_flat;
    logic [W-1:0]   bank_rd_flat;
    logic [DBW-1:0] deb_len_reg, presc_reg;
    logic           ctrl_en_reg;
    logic           irq_reg;
    logic           ack_reg;
    logic [31:0]    rdata_reg;
    logic [31:0]    rd_mux;
    logic           strobe;

    // Address decode: banks live below 0x100, globals at 0x100..0x108.
    logic [19:0] addr;
    logic        bank_area;
    logic [2:0]  bank_idx;
    logic [2:0]  reg_idx;
    logic        deb_hit, ctrl_hit, info_hit;
    logic        unused_bits;

    assign addr      = sys.sys_addr[19:0];
    assign bank_area = (addr[19:8] == 12'h000) && (addr[1:0] == 2'b00);
    assign bank_idx  = addr[7:5];
    assign reg_idx   = addr[4:2];
    assign deb_hit   = (addr == 20'h00100);
    assign ctrl_hit  = (addr == 20'h00104);
    assign info_hit  = (addr == 20'h00108);
    assign unused_bits = ^{sys.sys_addr[31:20], sys.sys_wdata};

    assign rise = deb_reg & ~deb_q_reg;
    assign fall = ~deb_reg & deb_q_reg;

    assign strobe = (deb_len_reg != '0) && (presc_reg == (deb_len_reg - DBW'(1)));

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bank
            logic [DW-1:0] dir_reg, dout_reg, ien_r_reg, ien_f_reg, ists_reg;
            logic [DW-1:0] wdat, w1c, bank_rd;
            logic          bank_wr;

            assign bank_wr = sys.sys_wen && bank_area && (bank_idx == 3'(gi));
            assign wdat    = sys.sys_wdata[DW-1:0];
            assign w1c     = (bank_wr && (reg_idx == 3'd5)) ? wdat : '0;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    dir_reg   <= '0;
                    dout_reg  <= '0;
                    ien_r_reg <= '0;
                    ien_f_reg <= '0;
                    ists_reg  <= '0;
                end else begin
                    if (bank_wr) begin
                        case (reg_idx)
                            3'd0:    dir_reg   <= wdat;
                            3'd1:    dout_reg  <= wdat;
                            3'd3:    ien_r_reg <= wdat;
                            3'd4:    ien_f_reg <= wdat;
                            3'd6:    dout_reg  <= dout_reg | wdat;
                            3'd7:    dout_reg  <= dout_reg & ~wdat;
                            default: ;
                        endcase
                    end
                    // New events are ORed in after the clear so a coincident edge survives.
                    ists_reg <= (ists_reg & ~w1c)
                              | (rise[gi*DW +: DW] & ien_r_reg)
                              | (fall[gi*DW +: DW] & ien_f_reg);
                end
            end

            always_comb begin
                bank_rd = '0;
                case (reg_idx)
                    3'd0:    bank_rd = dir_reg;
                    3'd1:    bank_rd = dout_reg;
                    3'd2:    bank_rd = deb_reg[gi*DW +: DW];
                    3'd3:    bank_rd = ien_r_reg;
                    3'd4:    bank_rd = ien_f_reg;
                    3'd5:    bank_rd = ists_reg;
                    default: bank_rd = '0;
                endcase
            end

            assign gpio_dir_o[gi*DW +: DW]   = dir_reg;
            assign gpio_dat_o[gi*DW +: DW]   = dout_reg;
            assign ists_flat[gi*DW +: DW]    = ists_reg;
            assign bank_rd_flat[gi*DW +: DW] = bank_rd;
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        if (deb_hit) begin
            rd_mux = 32'(deb_len_reg);
        end else if (ctrl_hit) begin
            rd_mux = {30'h0, |ists_flat, ctrl_en_reg};
        end else if (info_hit) begin
            rd_mux = {16'h0, 8'(NB), 8'(DW)};
        end else if (bank_area) begin
            for (int b = 0; b < NB; b++) begin
                if (bank_idx == 3'(b)) begin
                    rd_mux = 32'(bank_rd_flat[b*DW +: DW]);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            smp_reg     <= '0;
            deb_reg     <= '0;
            deb_q_reg   <= '0;
            presc_reg   <= '0;
            deb_len_reg <= '0;
            ctrl_en_reg <= 1'b0;
            irq_reg     <= 1'b0;
            ack_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            sync1_reg <= gpio_dat_i;
            sync2_reg <= sync1_reg;
            deb_q_reg <= deb_reg;

            // A bit only moves once two consecutive strobes saw the same pin level.
            if (deb_len_reg == '0) begin
                deb_reg <= sync2_reg;
            end else if (strobe) begin
                deb_reg <= (sync2_reg & ~(sync2_reg ^ smp_reg)) | (deb_reg & (sync2_reg ^ smp_reg));
                smp_reg <= sync2_reg;
            end

            if (sys.sys_wen && deb_hit) begin
                presc_reg <= '0;
            end else if ((deb_len_reg == '0) || strobe) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + DBW'(1);
            end

            if (sys.sys_wen && deb_hit) begin
                deb_len_reg <= sys.sys_wdata[DBW-1:0];
            end
            if (sys.sys_wen && ctrl_hit) begin
                ctrl_en_reg <= sys.sys_wdata[0];
            end

            irq_reg <= ctrl_en_reg & (|ists_flat);
            ack_reg <= sys.sys_wen | sys.sys_ren;
            if (sys.sys_ren) begin
                rdata_reg <= rd_mux;
            end
        end
    end

    assign irq_o         = irq_reg;
    assign sys.sys_ack   = ack_reg;
    assign sys.sys_rdata = rdata_reg;
    assign sys.sys_err   = 1'b0;

endmodule
